// File: rtl/rop3_pkg.sv
// Shared ROP3 definitions: named raster-op modes, minterm ordering and the
// mode-decoder state encoding, common to the evaluator and the decoder.
package rop3_pkg;

  localparam logic [7:0] ROP_BLACKNESS   = 8'h00;
  localparam logic [7:0] ROP_NOTSRCERASE = 8'h11;
  localparam logic [7:0] ROP_NOTSRCCOPY  = 8'h33;
  localparam logic [7:0] ROP_DSTINVERT   = 8'h55;
  localparam logic [7:0] ROP_PATINVERT   = 8'h5A;
  localparam logic [7:0] ROP_SRCINVERT   = 8'h66;
  localparam logic [7:0] ROP_SRCAND      = 8'h88;
  localparam logic [7:0] ROP_XOR3        = 8'h96;
  localparam logic [7:0] ROP_DSTCOPY     = 8'hAA;
  localparam logic [7:0] ROP_SRCCOPY     = 8'hCC;
  localparam logic [7:0] ROP_SRCPAINT    = 8'hEE;
  localparam logic [7:0] ROP_PATCOPY     = 8'hF0;
  localparam logic [7:0] ROP_WHITENESS   = 8'hFF;

  // Minterm index is {P,S,D} with P as the MSB, so PATCOPY = F0 etc.
  localparam int MT_P_BIT = 2;
  localparam int MT_S_BIT = 1;
  localparam int MT_D_BIT = 0;

  function automatic logic [2:0] minterm_idx(input logic p, input logic s, input logic d);
    logic [2:0] idx;
    idx           = 3'b000;
    idx[MT_P_BIT] = p;
    idx[MT_S_BIT] = s;
    idx[MT_D_BIT] = d;
    return idx;
  endfunction

  typedef logic [0:0] dec_state_t;
  localparam dec_state_t ST_IDLE = 1'b0;
  localparam dec_state_t ST_SCAN = 1'b1;

endpackage

// File: rtl/rop3_mode_decoder.sv
// Learns an unknown ROP3 mode by observing P/S/D/Result samples, one lane
// per cycle, accumulating minterms and flagging contradictory observations.
module rop3_mode_decoder
  import rop3_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] P,
  input  logic [N-1:0] S,
  input  logic [N-1:0] D,
  input  logic [N-1:0] Result,
  output logic [7:0]   Mode,
  output logic [7:0]   known_mask,
  output logic         conflict,
  output logic         mode_valid,
  output logic         busy
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a sample transfers on a rising edge where in_valid and
  // in_ready are both high; the source must hold P/S/D/Result until then.

  dec_state_t    state;
  logic [LW-1:0] lane;
  logic [N-1:0]  p_q, s_q, d_q, r_q;
  logic [7:0]    mode_q, mask_q;
  logic          conflict_q;

  logic [2:0]    idx;
  logic          res_bit;
  logic          last_lane;

  always_comb begin
    idx       = minterm_idx(p_q[lane], s_q[lane], d_q[lane]);
    res_bit   = r_q[lane];
    last_lane = (lane == LW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lane       <= '0;
      p_q        <= '0;
      s_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      mode_q     <= ROP_BLACKNESS;
      mask_q     <= 8'h00;
      conflict_q <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      lane       <= '0;
      mode_q     <= ROP_BLACKNESS;
      mask_q     <= 8'h00;
      conflict_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            p_q   <= P;
            s_q   <= S;
            d_q   <= D;
            r_q   <= Result;
            lane  <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // A contradicting lane only raises the flag; first-learned bits stay.
          if (mask_q[idx] && (mode_q[idx] != res_bit)) begin
            conflict_q <= 1'b1;
          end else begin
            mode_q[idx] <= res_bit;
            mask_q[idx] <= 1'b1;
          end
          if (last_lane) begin
            state <= ST_IDLE;
            lane  <= '0;
          end else begin
            lane <= lane + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == ST_IDLE) & ~clear;
  assign busy       = (state == ST_SCAN);
  assign Mode       = mode_q;
  assign known_mask = mask_q;
  assign conflict   = conflict_q;
  assign mode_valid = (mask_q == 8'hFF) & ~conflict_q;

endmodule

// File: tb/tb_rop3_mode_decoder.sv
// Directed and randomized bench for rop3_mode_decoder (N=8 main instance,
// N=32 instance for back-to-back throughput).
module tb_rop3_mode_decoder;

  localparam int N  = 8;
  localparam int N2 = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clear, in_valid;
  logic [N-1:0] p, s, d, r;
  logic         in_ready, conflict, mode_valid, busy;
  logic [7:0]   mode, known_mask;

  rop3_mode_decoder #(.N(N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .P(p), .S(s), .D(d), .Result(r),
    .Mode(mode), .known_mask(known_mask), .conflict(conflict),
    .mode_valid(mode_valid), .busy(busy)
  );

  logic          rst32, valid32;
  logic [N2-1:0] p32, s32, d32, r32;
  logic          ready32, conflict32, mode_valid32, busy32;
  logic [7:0]    mode32, mask32;

  rop3_mode_decoder #(.N(N2)) dut32 (
    .clk(clk), .rst(rst32), .clear(1'b0), .in_valid(valid32), .in_ready(ready32),
    .P(p32), .S(s32), .D(d32), .Result(r32),
    .Mode(mode32), .known_mask(mask32), .conflict(conflict32),
    .mode_valid(mode_valid32), .busy(busy32)
  );

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard of acceptance cycles for the N=32 instance
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  always @(posedge clk) begin
    if (valid32 && ready32) acc_q.push_back(cyc);
    cyc++;
  end

  // reference model: per-minterm knowledge table
  logic [7:0] m_mode, m_mask;
  logic       m_conf;

  task automatic model_reset();
    m_mode = 8'h00;
    m_mask = 8'h00;
    m_conf = 1'b0;
  endtask

  task automatic model_apply(input logic [N-1:0] mp, input logic [N-1:0] ms,
                             input logic [N-1:0] md, input logic [N-1:0] mr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = 4 * int'(mp[k]) + 2 * int'(ms[k]) + int'(md[k]);
      if (m_mask[i] && (m_mode[i] != mr[k])) m_conf = 1'b1;
      else begin
        m_mode[i] = mr[k];
        m_mask[i] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".mode"}, 32'(mode), 32'(m_mode));
    check({tag, ".mask"}, 32'(known_mask), 32'(m_mask));
    check({tag, ".conflict"}, 32'(conflict), 32'(m_conf));
    check({tag, ".mode_valid"}, 32'(mode_valid), 32'((m_mask == 8'hFF) && !m_conf));
  endtask

  // driver: offer a sample, wait for acceptance, then measure scan length
  task automatic send(input logic [N-1:0] sp, input logic [N-1:0] ss,
                      input logic [N-1:0] sd, input logic [N-1:0] sr, input string tag);
    int guard;
    int n;
    p = sp; s = ss; d = sd; r = sr;
    in_valid = 1'b1;
    guard = 0;
    #0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check({tag, ".ready_timeout"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    model_apply(sp, ss, sd, sr);
    check({tag, ".busy_cycles"}, 32'(n), 32'(N));
    check_model(tag);
  endtask

  function automatic logic [N-1:0] apply_mode(input logic [7:0] tm, input logic [N-1:0] ap,
                                              input logic [N-1:0] as_, input logic [N-1:0] ad);
    logic [N-1:0] o;
    for (int k = 0; k < N; k++) o[k] = tm[4 * int'(ap[k]) + 2 * int'(as_[k]) + int'(ad[k])];
    return o;
  endfunction

  initial begin
    logic [7:0]   tm;
    logic [N-1:0] rp, rs, rd, rr;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    p = '0; s = '0; d = '0; r = '0;
    rst32 = 1'b1; valid32 = 1'b0;
    p32 = $urandom; s32 = $urandom; d32 = $urandom; r32 = $urandom;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    rst32 = 1'b0;
    valid32 = 1'b1;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.busy", 32'(busy), 32'd0);
    check_model("reset");

    // XOR3 learned from a single full-coverage sample
    send(8'hF0, 8'hCC, 8'hAA, 8'h96, "xor3");
    check("xor3.const_mode", 32'(mode), 32'h96);
    check("xor3.const_valid", 32'(mode_valid), 32'd1);

    // single minterm, then contradiction on minterm 0
    clear = 1'b1; tick(); clear = 1'b0; model_reset();
    send(8'h00, 8'h00, 8'h00, 8'h00, "mt0");
    check("mt0.const_mask", 32'(known_mask), 32'h01);
    send(8'hF0, 8'hCC, 8'hAA, 8'h97, "conf");
    check("conf.const_conflict", 32'(conflict), 32'd1);
    check("conf.mode0", 32'(mode[0]), 32'd0);

    // randomized accumulation against a hidden mode, with occasional corruption
    clear = 1'b1; tick(); clear = 1'b0; model_reset();
    tm = 8'($urandom);
    for (int it = 0; it < 8; it++) begin
      rp = N'($urandom); rs = N'($urandom); rd = N'($urandom);
      rr = apply_mode(tm, rp, rs, rd);
      if ($urandom_range(0, 3) == 0) rr[$urandom_range(0, N - 1)] ^= 1'b1;
      send(rp, rs, rd, rr, "rand");
    end

    // clear aborts a scan at edge t+3
    clear = 1'b1; tick(); clear = 1'b0; model_reset();
    p = 8'hF0; s = 8'hCC; d = 8'hAA; r = 8'h96;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("abort.busy_t", 32'(busy), 32'd1);
    tick(); tick();
    clear = 1'b1;
    tick();
    check("abort.mask", 32'(known_mask), 32'h00);
    check("abort.conflict", 32'(conflict), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    clear = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);

    // clear wins over in_valid in IDLE
    clear = 1'b1; in_valid = 1'b1;
    #1;
    check("clrprio.in_ready", 32'(in_ready), 32'd0);
    tick();
    check("clrprio.busy", 32'(busy), 32'd0);
    clear = 1'b0; in_valid = 1'b0;

    // rst at edge t+4 of a scan
    p = 8'hF0; s = 8'hCC; d = 8'hAA; r = 8'h96;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("midrst.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    model_reset();
    check("midrst.busy", 32'(busy), 32'd0);
    check_model("midrst");
    rst = 1'b0;
    #1;
    check("midrst.in_ready", 32'(in_ready), 32'd1);

    // back-to-back spacing on the N=32 instance
    repeat (40) tick();
    valid32 = 1'b0;
    check("tput.count_ge3", 32'(acc_q.size() >= 3), 32'd1);
    for (int i = 1; i < acc_q.size(); i++) exp_q.push_back(acc_q[i - 1] + 32'(N2 + 1));
    for (int i = 1; i < acc_q.size(); i++) check("tput.spacing", acc_q[i], exp_q[i - 1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
